gmp_feature_collector: RTL

GMP_FEATURE_COLLECTOR -- requirements
Module: gmp_feature_collector

---
 rtl/gmp_pkg.sv | 16 +
 rtl/gmp_feature_collector_if.sv | 32 +++
 rtl/gmp_feature_collector_bank.sv | 68 ++++++
 rtl/gmp_feature_collector.sv | 83 ++++++++
 4 files changed

// File: rtl/gmp_pkg.sv
// Shared sizing for the GMP feature collector and the downstream global max-pool.
package gmp_pkg;

  localparam int GMP_BIT_SIZE    = 8;
  localparam int GMP_ACTIVATIONS = 36;
  localparam int GMP_CHANNELS    = 10;

  // Keeps counters at least one bit wide when a dimension collapses to 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GMP_IDX_W = idx_width(GMP_ACTIVATIONS);
  localparam int GMP_CH_W  = idx_width(GMP_CHANNELS);

endpackage

// File: rtl/gmp_feature_collector_if.sv
// Pixel-in / channel-vector-out handshake bundle of the feature collector.
interface gmp_feature_collector_if
  import gmp_pkg::*;
#(
  parameter int BIT_SIZE        = GMP_BIT_SIZE,
  parameter int ACTIVATIONS_GMP = GMP_ACTIVATIONS,
  parameter int CHANNELS        = GMP_CHANNELS
);

  localparam int CH_W  = idx_width(CHANNELS);
  localparam int VEC_W = BIT_SIZE * ACTIVATIONS_GMP;

  logic signed [BIT_SIZE-1:0] in_pixel;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [VEC_W-1:0]    out_vec;
  logic                       out_valid;
  logic                       out_ready;
  logic [CH_W-1:0]            out_channel;
  logic                       out_last;

  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_vec, out_valid, out_channel, out_last
  );

  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_vec, out_valid, out_channel, out_last
  );

endinterface

// File: rtl/gmp_feature_collector_bank.sv
// One ping-pong bank: pixel storage, its own write index and a full flag.
module gmp_bank
  import gmp_pkg::*;
#(
  parameter int BIT_SIZE = GMP_BIT_SIZE,
  parameter int DEPTH    = GMP_ACTIVATIONS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [BIT_SIZE-1:0]       wr_data,
  input  logic                      rd_done,
  output logic [BIT_SIZE*DEPTH-1:0] data,
  output logic                      full,
  output logic                      wr_last
);

  localparam int IDX_W = idx_width(DEPTH);

  logic [BIT_SIZE-1:0] mem_q [DEPTH];
  logic [BIT_SIZE-1:0] mem_d [DEPTH];
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                full_q, full_d;

  assign wr_last = (idx_q == IDX_W'(DEPTH - 1));
  assign full    = full_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign data[g*BIT_SIZE +: BIT_SIZE] = mem_q[g];
  end

  always_comb begin
    mem_d  = mem_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      idx_d  = '0;
      full_d = 1'b0;
    end else begin
      // A bank is never written while full nor read while filling, so these never collide.
      if (rd_done) full_d = 1'b0;
      if (wr_en) begin
        mem_d[idx_q] = wr_data;
        if (wr_last) begin
          idx_d  = '0;
          full_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/gmp_feature_collector.sv
// Collects a streamed channel map into ping-pong banks and hands whole channels to global max-pool.
module gmp_feature_collector
  import gmp_pkg::*;
#(
  parameter int BIT_SIZE        = GMP_BIT_SIZE,
  parameter int ACTIVATIONS_GMP = GMP_ACTIVATIONS,
  parameter int CHANNELS        = GMP_CHANNELS
) (
  input logic                     clk,
  input logic                     rst,
  input logic                     clear,
  gmp_feature_collector_if.slave  bus
);

  localparam int CH_W  = idx_width(CHANNELS);
  localparam int VEC_W = BIT_SIZE * ACTIVATIONS_GMP;

  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             in_fire, out_fire;
  logic [1:0]       wr_en, rd_done, bank_full, bank_last;
  logic [VEC_W-1:0] bank_data [2];

  // Handshake outputs come only from registered flags and selects.
  assign bus.in_ready    = !bank_full[wr_sel_q];
  assign bus.out_valid   = bank_full[rd_sel_q];
  assign bus.out_vec     = bank_data[rd_sel_q];
  assign bus.out_channel = ch_q;
  assign bus.out_last    = (ch_q == CH_W'(CHANNELS - 1));

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign wr_en    = in_fire  ? (wr_sel_q ? 2'b10 : 2'b01) : 2'b00;
  assign rd_done  = out_fire ? (rd_sel_q ? 2'b10 : 2'b01) : 2'b00;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    gmp_bank #(
      .BIT_SIZE (BIT_SIZE),
      .DEPTH    (ACTIVATIONS_GMP)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .wr_en   (wr_en[b]),
      .wr_data (bus.in_pixel),
      .rd_done (rd_done[b]),
      .data    (bank_data[b]),
      .full    (bank_full[b]),
      .wr_last (bank_last[b])
    );
  end

  always_comb begin
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    ch_d     = ch_q;
    if (clear) begin
      wr_sel_d = 1'b0;
      rd_sel_d = 1'b0;
      ch_d     = '0;
    end else begin
      if (in_fire && bank_last[wr_sel_q]) wr_sel_d = !wr_sel_q;
      if (out_fire) begin
        rd_sel_d = !rd_sel_q;
        ch_d     = bus.out_last ? '0 : ch_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      ch_q     <= '0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      ch_q     <= ch_d;
    end
  end

endmodule
